spi_tx_fsm: RTL and testbench
=============================

Name: spi_tx_fsm

Overview:
- Parallel-to-serial transmitter for the internal single-wire serial link; the transmit end of the existing serial-to-parallel collector.
- Accepts a PARALLEL_WIDTH-bit word through a valid/ready handshake and emits a one-cycle serial_ready start strobe.
- Then emits the word LSB-first, one bit per clock.
- A one-word holding register allows back-to-back frames with no idle gap.

Parameters:
- PARALLEL_WIDTH, 96, frame payload width in bits (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- parallel_valid  input  1  upstream word on parallel_in is valid.
- parallel_in  input  PARALLEL_WIDTH  word to transmit; bit 0 goes out first.
- parallel_ready  output  1  holding register empty; a transfer occurs when valid and ready are both 1 at a rising edge.
- serial_ready  output  1  frame start strobe, high for exactly one cycle per frame.
- serial_out  output  1  serial data bit.
- tx_busy  output  1  high in START or SHIFT.

Behaviour:
- Reset (async assert, sync release). Values:
  - state = IDLE
  - hold_full = 0
  - shift register = 0
  - bit counter = PARALLEL_WIDTH-1
  - serial_ready = 0, serial_out = 0, tx_busy = 0
  - parallel_ready = 1 once reset deasserts.
- parallel_ready = ~hold_full, driven from the register only; no combinational path from parallel_valid.
- Holding register:
  - Loads parallel_in on handshake and sets hold_full.
  - Cleared when its word moves into the shift register.
  - A new handshake and a move to the shift register may occur on the same edge; the holding register then reloads and hold_full stays 1.
- States (enum IDLE, START, SHIFT), with registered outputs decoded from state:
  - IDLE: serial_ready = 0, serial_out = 0. If hold_full, then on the next edge: shift register <= hold, hold_full cleared, counter <= PARALLEL_WIDTH-1, go to START.
  - START: serial_ready = 1, serial_out = 0. Always go to SHIFT next.
  - SHIFT: serial_ready = 0, serial_out = shift[0]. Each edge shifts right by one and decrements the counter.
  - SHIFT exit: when counter == 0 (last bit on the wire), go to START if hold_full (reloading shift and counter as in IDLE), else go to IDLE.
- Frame timing:
  - Handshake at edge of cycle c: serial_ready = 1 in cycle c+2.
  - Data bits 0..PARALLEL_WIDTH-1 appear in cycles c+3 .. c+2+PARALLEL_WIDTH.
  - Back-to-back frame period is PARALLEL_WIDTH+1 cycles. The next START cycle coincides with the collector's DONE cycle, so the collector re-enters COLLECT directly.
- Bit counter:
  - Width $clog2(PARALLEL_WIDTH); counts down and never wraps in normal operation.
  - Any value reaching 0 outside SHIFT is ignored.
- Full/empty:
  - At most two words in flight: one in the shift register, one in hold.
  - A third word is back-pressured (parallel_ready = 0) until hold drains at the next START transition.
- Reset mid-frame: the frame is aborted immediately. serial_ready and serial_out go to 0 and the held word is discarded. The collector recovers because its next frame begins with a fresh serial_ready.
- parallel_in is ignored while parallel_valid = 0 or parallel_ready = 0.

Decomposition:
- Shared package spi_pkg:
  - SPI_FRAME_WIDTH = 96.
  - spi_tx_state_t enum {IDLE, START, SHIFT}, one-hot 3-bit encoding.
- Keep the parameter default tied to SPI_FRAME_WIDTH.
- No sub-module needed. The hold register, shift register and counter are each a few lines and stay inline.

Test Plan:
- Single word 96'h0000_0000_0000_0000_0000_0001, handshake in cycle 10 -> serial_ready = 1 only in cycle 12; serial_out = 1 in cycle 13, 0 in cycles 14-108; tx_busy = 0 from cycle 109.
- Loopback into the collector (active-low reset driven as ~reset) with word 96'h0123_4567_89AB_CDEF_FEDC_BA98 -> collector parallel_ready pulses once and parallel_out equals the sent word.
- Back-to-back: words A = 96'hAAAA..., B = 96'h5555... offered in consecutive cycles -> both accepted with parallel_ready never low longer than needed; second serial_ready exactly 97 cycles after the first; collector captures A then B.
- Back-pressure: valid held high with three words -> third handshake stalls (parallel_ready = 0) until the second frame's START cycle; no word is lost or duplicated.
- Reset asserted during data bit 40 of a frame with a second word held -> serial_ready = serial_out = tx_busy = 0 asynchronously; after release, parallel_ready = 1 and a new word transmits correctly with no remnant of the held word.
- PARALLEL_WIDTH = 8, word 8'hB4 -> serial_out sequence 0,0,1,0,1,1,0,1 after the start strobe; frame period 9 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the single-wire serial link: frame width and transmitter states.
package spi_pkg;

    localparam int unsigned SPI_FRAME_WIDTH = 96;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        START = 3'b010,
        SHIFT = 3'b100
    } spi_tx_state_t;

endpackage : spi_pkg

// File: rtl/spi_tx_fsm_if.sv
// Parallel handshake and serial-side signals of the serial transmitter.
interface spi_tx_fsm_if #(
    parameter int unsigned PARALLEL_WIDTH = spi_pkg::SPI_FRAME_WIDTH
);
    logic                      parallel_valid;
    logic [PARALLEL_WIDTH-1:0] parallel_in;
    logic                      parallel_ready;
    logic                      serial_ready;
    logic                      serial_out;
    logic                      tx_busy;

    // master: upstream word source and serial observer; slave: the transmitter
    modport master (
        output parallel_valid,
        output parallel_in,
        input  parallel_ready,
        input  serial_ready,
        input  serial_out,
        input  tx_busy
    );

    modport slave (
        input  parallel_valid,
        input  parallel_in,
        output parallel_ready,
        output serial_ready,
        output serial_out,
        output tx_busy
    );
endinterface : spi_tx_fsm_if

// File: rtl/spi_tx_fsm.sv
// Parallel-to-serial transmitter: start strobe then LSB-first payload, with a one-word
// holding register so consecutive frames leave no idle gap.
module spi_tx_fsm
    import spi_pkg::*;
#(
    parameter int unsigned PARALLEL_WIDTH = SPI_FRAME_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    spi_tx_fsm_if.slave  bus
);

    localparam int unsigned CNT_W = (PARALLEL_WIDTH > 1) ? $clog2(PARALLEL_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PARALLEL_WIDTH - 1);

    spi_tx_state_t             state, state_nxt;
    logic [PARALLEL_WIDTH-1:0] hold, hold_nxt;
    logic                      hold_full, hold_full_nxt;
    logic [PARALLEL_WIDTH-1:0] shift, shift_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      ready_q, ready_nxt;
    logic                      sready_q, sready_nxt;
    logic                      sout_q, sout_nxt;
    logic                      busy_q, busy_nxt;
    logic                      handshake;
    logic                      load;

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            cnt       <= CNT_INIT;
            ready_q   <= 1'b1;
            sready_q  <= 1'b0;
            sout_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            shift     <= shift_nxt;
            cnt       <= cnt_nxt;
            ready_q   <= ready_nxt;
            sready_q  <= sready_nxt;
            sout_q    <= sout_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        shift_nxt     = shift;
        cnt_nxt       = cnt;
        load          = 1'b0;
        handshake     = bus.parallel_valid & ready_q;

        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_nxt = shift >> 1;
                if (cnt == '0) begin
                    if (hold_full) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (load) begin
            shift_nxt = hold;
            cnt_nxt   = CNT_INIT;
        end

        // A same-edge reload keeps the holding register full
        hold_full_nxt = (hold_full & ~load) | handshake;
        if (handshake) begin
            hold_nxt = bus.parallel_in;
        end

        ready_nxt  = ~hold_full_nxt;
        sready_nxt = (state_nxt == START);
        sout_nxt   = (state_nxt == SHIFT) & shift_nxt[0];
        busy_nxt   = (state_nxt != IDLE);
    end

    assign bus.parallel_ready = ready_q;
    assign bus.serial_ready   = sready_q;
    assign bus.serial_out     = sout_q;
    assign bus.tx_busy        = busy_q;

endmodule : spi_tx_fsm

// File: tb/tb_spi_tx_fsm.sv
// Scoreboard bench for spi_tx_fsm: a receive model rebuilds frames from the serial stream
// and compares them against words queued at handshake time; timing checked cycle by cycle.
module tb_spi_tx_fsm;
    import spi_pkg::*;

    localparam int unsigned W  = SPI_FRAME_WIDTH;
    localparam int unsigned W8 = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_tx_fsm_if #(.PARALLEL_WIDTH(W))  bus ();
    spi_tx_fsm_if #(.PARALLEL_WIDTH(W8)) bus8 ();

    spi_tx_fsm #(.PARALLEL_WIDTH(W))  dut  (.clk(clk), .reset(reset), .bus(bus));
    spi_tx_fsm #(.PARALLEL_WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard and receive model
    logic [W-1:0] exp_q[$];
    int           start_q[$];
    int           frames = 0;
    logic [W-1:0] rx;
    int           nbit = 0;
    bit           collecting = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            collecting = 1'b0;
            nbit       = 0;
        end else if (bus.serial_ready) begin
            check("strobe_mid_frame", 128'(collecting), 128'(0));
            collecting = 1'b1;
            nbit       = 0;
            start_q.push_back(cyc);
        end else if (collecting) begin
            rx[nbit] = bus.serial_out;
            nbit++;
            if (nbit == int'(W)) begin
                collecting = 1'b0;
                frames++;
                check("frame_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) check("frame", 128'(rx), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic [W-1:0] w, output int hs);
        int guard = 0;
        @(negedge clk);
        bus.parallel_valid = 1'b1;
        bus.parallel_in    = w;
        while (!bus.parallel_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", 128'(bus.parallel_ready), 128'(1));
        hs = cyc;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((exp_q.size() != 0 || bus.tx_busy || collecting) && g < 2000);
        check(tag, 128'(exp_q.size() == 0 && !bus.tx_busy), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, ha, hb, h1, h2, h3, f0;
        logic [W-1:0]  wa, wb;
        logic [W8-1:0] w1, w2;
        logic          exp_o;

        reset = 1'b0;
        bus.parallel_valid  = 1'b0;
        bus.parallel_in     = '0;
        bus8.parallel_valid = 1'b0;
        bus8.parallel_in    = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sready", 128'(bus.serial_ready), 128'(0));
        check("rst_sout",   128'(bus.serial_out),   128'(0));
        check("rst_busy",   128'(bus.tx_busy),      128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(bus.parallel_ready), 128'(1));

        // Single word: strobe at c+2, bit0 at c+3, idle after c+98
        push(96'h1, c);
        bus.parallel_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check("t1_sready", 128'(bus.serial_ready), 128'(cyc == c + 2));
            check("t1_sout",   128'(bus.serial_out),   128'(cyc == c + 3));
            check("t1_busy",   128'(bus.tx_busy),      128'(cyc >= c + 2 && cyc <= c + 2 + int'(W)));
        end
        wait_idle("t1_drain");

        // Loopback word
        push(96'h0123_4567_89AB_CDEF_FEDC_BA98, c);
        bus.parallel_valid = 1'b0;
        wait_idle("t2_drain");

        // Back-to-back A then B
        start_q.delete();
        wa = {24{4'hA}};
        wb = {24{4'h5}};
        push(wa, ha);
        push(wb, hb);
        bus.parallel_valid = 1'b0;
        wait_idle("t3_drain");
        check("t3_hs_gap",    128'(hb - ha), 128'(2));
        check("t3_starts",    128'(start_q.size()), 128'(2));
        check("t3_start_lat", 128'(start_q[0] - ha), 128'(2));
        check("t3_period",    128'(start_q[1] - start_q[0]), 128'(W + 1));

        // Back-pressure: third word waits for the second frame's START
        f0 = frames;
        push({$urandom, $urandom, $urandom}, h1);
        push({$urandom, $urandom, $urandom}, h2);
        push({$urandom, $urandom, $urandom}, h3);
        bus.parallel_valid = 1'b0;
        wait_idle("t4_drain");
        check("t4_hs2",    128'(h2 - h1), 128'(2));
        check("t4_hs3",    128'(h3 - h1), 128'(W + 3));
        check("t4_frames", 128'(frames - f0), 128'(3));

        // Reset during data bit 40 with a second word held
        push({W{1'b1}}, h1);
        push(96'hDEAD_BEEF_0000_1111_2222_3333, h2);
        bus.parallel_valid = 1'b0;
        while (cyc < h1 + 43) @(negedge clk);
        check("t5_pre_sout", 128'(bus.serial_out), 128'(1));
        check("t5_pre_busy", 128'(bus.tx_busy),    128'(1));
        #2 reset = 1'b1;
        #1;
        check("t5_sready", 128'(bus.serial_ready), 128'(0));
        check("t5_sout",   128'(bus.serial_out),   128'(0));
        check("t5_busy",   128'(bus.tx_busy),      128'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        f0 = frames;
        repeat (2) @(negedge clk);
        check("t5_ready",      128'(bus.parallel_ready), 128'(1));
        check("t5_idle_after", 128'(bus.tx_busy),        128'(0));
        push(96'h0F0F_0000_FFFF_1234_5678_9ABC, c);
        bus.parallel_valid = 1'b0;
        wait_idle("t5_drain");
        check("t5_frames", 128'(frames - f0), 128'(1));

        // Narrow instance: B4 then 3C back to back, period 9
        w1 = 8'hB4;
        w2 = 8'h3C;
        @(negedge clk);
        c = cyc;
        check("t6_ready", 128'(bus8.parallel_ready), 128'(1));
        bus8.parallel_valid = 1'b1;
        bus8.parallel_in    = w1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (cyc == c + 1) bus8.parallel_in = w2;
            if (cyc == c + 2) check("t6_ready_back", 128'(bus8.parallel_ready), 128'(1));
            if (cyc == c + 3) bus8.parallel_valid = 1'b0;
            if (cyc >= c + 3 && cyc <= c + 10)       exp_o = w1[cyc - c - 3];
            else if (cyc >= c + 12 && cyc <= c + 19) exp_o = w2[cyc - c - 12];
            else                                     exp_o = 1'b0;
            check("t6_sready", 128'(bus8.serial_ready), 128'(cyc == c + 2 || cyc == c + 11));
            check("t6_sout",   128'(bus8.serial_out),   128'(exp_o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_tx_fsm
